// File: rtl/mtimer_pkg.sv
// mtimer_pkg: shared constants and helpers for the machine timer.
//   - MTIMER_XLEN: the only supported bus width
//   - MTIME_RESET / MTIMECMP_RESET: register reset values
//   - prescale_width(): counter width for a given PRESCALE (minimum 1 bit)
`include "mtimer_defs.vh"

package mtimer_pkg;

  localparam int MTIMER_XLEN = 32;

  localparam logic [63:0] MTIME_RESET    = 64'd0;
  localparam logic [63:0] MTIMECMP_RESET = `MTIMER_CMP_RESET;

  // A prescaler of 1 still needs a 1-bit counter so the port widths stay legal.
  function automatic int prescale_width(input int prescale);
    return (prescale > 1) ? $clog2(prescale) : 1;
  endfunction

endpackage

// File: rtl/mtimer_defs.vh
// Shared register-map definitions for the mtimer block.
// Word offsets are the value of addr[4:2] on the data bus.
`ifndef MTIMER_DEFS_VH
`define MTIMER_DEFS_VH

`define MTIMER_OFF_MTIME_LO    3'd0
`define MTIMER_OFF_MTIME_HI    3'd1
`define MTIMER_OFF_MTIMECMP_LO 3'd2
`define MTIMER_OFF_MTIMECMP_HI 3'd3
`define MTIMER_OFF_MSIP        3'd4

// mtimecmp comes out of reset at all-ones so no timer interrupt fires
// before software has programmed a compare value.
`define MTIMER_CMP_RESET       64'hFFFF_FFFF_FFFF_FFFF

`endif

// File: rtl/mtimer_prescaler.sv
// mtimer_prescaler: divides clk down to the mtime tick rate.
//   Parameter PRESCALE: clk cycles per tick, must be >= 1.
//   Ports:
//     clk   in   clock
//     rst_n in   synchronous active-low reset
//     tick  out  high for one cycle every PRESCALE cycles (every cycle when PRESCALE=1)
module mtimer_prescaler
  import mtimer_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = prescale_width(PRESCALE);
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  generate
    if (PRESCALE < 1) begin : g_bad_prescale
      $error("mtimer_prescaler: PRESCALE must be >= 1");
    end
  endgenerate

  logic [CW-1:0] count;

  // Count 0..PRESCALE-1 and wrap; the tick is the terminal count itself.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/mtimer.sv
// mtimer: memory-mapped RISC-V machine timer (bus responder).
//   Parameters: XLEN (must be 32), PRESCALE (clk cycles per mtime tick, >= 1).
//   Optional feature macro: MTIMER_MSIP_EN adds the msip register at offset 4
//   and drives msi_pending from it; otherwise offset 4 is unmapped and
//   msi_pending is tied low.
//   Ports:
//     clk, rst_n   clock and synchronous active-low reset
//     sel          bus address falls in this block's window
//     addr         byte address, only addr[4:2] decoded
//     wdata        store data
//     wenable      per-byte write strobes (0 = no write)
//     rdata        combinational read data (0 when sel is low or unmapped)
//     mti_pending  registered mtime >= mtimecmp
//     msi_pending  registered software interrupt (MTIMER_MSIP_EN only)
`include "mtimer_defs.vh"

module mtimer
  import mtimer_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int PRESCALE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            sel,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  input  logic [3:0]      wenable,
  output logic [XLEN-1:0] rdata,
  output logic            mti_pending,
  output logic            msi_pending
);

  generate
    if (XLEN != MTIMER_XLEN) begin : g_bad_xlen
      $error("mtimer: only XLEN=32 is supported");
    end
  endgenerate

  // Replace only the strobed bytes of a register word.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  strobe);
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (strobe[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic        tick;
  logic [2:0]  off;
  logic        wr;
  logic        wr_mtime_lo;
  logic        wr_mtime_hi;
  logic        wr_cmp_lo;
  logic        wr_cmp_hi;
  logic        addr_unused;

  assign addr_unused = ^{addr[XLEN-1:5], addr[1:0]};

  assign off         = addr[4:2];
  assign wr          = sel && (wenable != 4'b0000);
  assign wr_mtime_lo = wr && (off == `MTIMER_OFF_MTIME_LO);
  assign wr_mtime_hi = wr && (off == `MTIMER_OFF_MTIME_HI);
  assign wr_cmp_lo   = wr && (off == `MTIMER_OFF_MTIMECMP_LO);
  assign wr_cmp_hi   = wr && (off == `MTIMER_OFF_MTIMECMP_HI);

  mtimer_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  // A software write to either mtime word suppresses that cycle's increment
  // for the whole 64-bit counter, so a lo write never carries into hi.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mtime <= MTIME_RESET;
    end else if (wr_mtime_lo || wr_mtime_hi) begin
      if (wr_mtime_lo) mtime[31:0]  <= merge_bytes(mtime[31:0],  wdata, wenable);
      if (wr_mtime_hi) mtime[63:32] <= merge_bytes(mtime[63:32], wdata, wenable);
    end else if (tick) begin
      mtime <= mtime + 64'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mtimecmp <= MTIMECMP_RESET;
    end else begin
      if (wr_cmp_lo) mtimecmp[31:0]  <= merge_bytes(mtimecmp[31:0],  wdata, wenable);
      if (wr_cmp_hi) mtimecmp[63:32] <= merge_bytes(mtimecmp[63:32], wdata, wenable);
    end
  end

  // Compare on the current register values; the result lands one edge later,
  // which is why a compare write shows up on mti_pending only at the next edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mti_pending <= 1'b0;
    end else begin
      mti_pending <= (mtime >= mtimecmp);
    end
  end

`ifdef MTIMER_MSIP_EN
  logic msip;

  // Only bit 0 exists, so only byte lane 0 can change it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      msip <= 1'b0;
    end else if (wr && (off == `MTIMER_OFF_MSIP) && wenable[0]) begin
      msip <= wdata[0];
    end
  end

  assign msi_pending = msip;
`else
  assign msi_pending = 1'b0;
`endif

  // Reads are pure decode of current state; the CPU presents an address
  // every cycle so reading must never disturb anything.
  always_comb begin
    rdata = '0;
    if (sel) begin
      case (off)
        `MTIMER_OFF_MTIME_LO:    rdata = mtime[31:0];
        `MTIMER_OFF_MTIME_HI:    rdata = mtime[63:32];
        `MTIMER_OFF_MTIMECMP_LO: rdata = mtimecmp[31:0];
        `MTIMER_OFF_MTIMECMP_HI: rdata = mtimecmp[63:32];
`ifdef MTIMER_MSIP_EN
        `MTIMER_OFF_MSIP:        rdata = {31'd0, msip};
`endif
        default:                 rdata = '0;
      endcase
    end
  end

endmodule
